// File: rtl/paper_soccer_pkg.sv
// Shared definitions for the paper-soccer blocks: directions, colours, controller states.
package paper_soccer_pkg;

   localparam logic [2:0] DIR_A = 3'd0;
   localparam logic [2:0] DIR_B = 3'd1;
   localparam logic [2:0] DIR_C = 3'd2;
   localparam logic [2:0] DIR_D = 3'd3;
   localparam logic [2:0] DIR_E = 3'd4;
   localparam logic [2:0] DIR_F = 3'd5;
   localparam logic [2:0] DIR_G = 3'd6;
   localparam logic [2:0] DIR_H = 3'd7;

   localparam logic COLOR_BLUE = 1'b0;
   localparam logic COLOR_RED  = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_TURN,
      ST_RD_SRC,
      ST_CHK,
      ST_RD_DST,
      ST_WR_SRC,
      ST_WR_DST,
      ST_UPDATE,
      ST_DONE
   } state_t;

   function automatic logic [2:0] opp_dir(input logic [2:0] dir);
      return dir + 3'd4;
   endfunction

endpackage

// File: rtl/move_decoder.sv
// Combinational direction decode: step vector plus the edge-mask bits for both endpoints.
module move_decoder
   import paper_soccer_pkg::*;
(
   input  logic        [2:0] dir,
   output logic signed [1:0] dx,
   output logic signed [1:0] dy,
   output logic        [7:0] dir_bit,
   output logic        [7:0] opp_bit
);

   localparam logic signed [1:0] POS  = 2'sb01;
   localparam logic signed [1:0] ZERO = 2'sb00;
   localparam logic signed [1:0] NEG  = 2'sb11;

   always_comb begin
      dx = ZERO;
      dy = ZERO;
      case (dir)
         DIR_A:   begin dx = ZERO; dy = POS;  end
         DIR_B:   begin dx = POS;  dy = POS;  end
         DIR_C:   begin dx = POS;  dy = ZERO; end
         DIR_D:   begin dx = POS;  dy = NEG;  end
         DIR_E:   begin dx = ZERO; dy = NEG;  end
         DIR_F:   begin dx = NEG;  dy = NEG;  end
         DIR_G:   begin dx = NEG;  dy = ZERO; end
         DIR_H:   begin dx = NEG;  dy = POS;  end
         default: begin dx = ZERO; dy = ZERO; end
      endcase
      dir_bit = 8'd1 << dir;
      opp_bit = 8'd1 << opp_dir(dir);
   end

endmodule

// File: rtl/move_arbiter.sv
// Paper-soccer turn controller: owns ball and turn, validates each move against board RAM
// edge masks, marks both endpoints, and decides bounces, goals and stuck positions.
module move_arbiter
   import paper_soccer_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter int   LENGTH   = 10,
   parameter logic AI_COLOR = 1'b1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        game_start,
   input  logic        hum_valid,
   input  logic [2:0]  hum_dir,
   output logic        hum_ready,
   output logic        ai_turn,
   input  logic        ai_dir_valid,
   input  logic [2:0]  ai_dir,
   input  logic        ai_idle,
   output logic [7:0]  ball_x,
   output logic [7:0]  ball_y,
   output logic        turn,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        move_done,
   output logic        move_reject,
   output logic        winner_valid,
   output logic        winner
);

   localparam logic [7:0]  X_MID  = 8'(WIDTH / 2);
   localparam logic [7:0]  Y_MID  = 8'(LENGTH / 2);
   localparam logic [7:0]  Y_GOAL = 8'(LENGTH);
   localparam logic [15:0] ROW    = 16'(WIDTH + 1);

   state_t state, state_nxt;

   logic [7:0] ball_x_q, ball_y_q;
   logic       turn_q;
   logic [2:0] dir_q;
   logic [7:0] src_mask, dst_mask;
   logic       ai_started;
   logic       winner_q;

   logic signed [1:0] dx, dy;
   logic [7:0] dir_bit, opp_bit;
   logic [7:0] dst_x, dst_y;
   logic [15:0] src_addr, dst_addr;
   logic       hum_turn, accept_hum, accept_ai, accept, ai_fire, illegal, stuck;
   logic [2:0] dir_in;

   function automatic logic [15:0] pt_addr(input logic [7:0] x, input logic [7:0] y);
      return ({8'd0, y} * ROW) + {8'd0, x};
   endfunction

   move_decoder u_dec (
      .dir     (dir_q),
      .dx      (dx),
      .dy      (dy),
      .dir_bit (dir_bit),
      .opp_bit (opp_bit)
   );

   // Ball only moves in UPDATE, so the destination can be derived from the live ball.
   assign dst_x    = ball_x_q + {{6{dx[1]}}, dx};
   assign dst_y    = ball_y_q + {{6{dy[1]}}, dy};
   assign src_addr = pt_addr(ball_x_q, ball_y_q);
   assign dst_addr = pt_addr(dst_x, dst_y);

   assign hum_turn   = (turn_q != AI_COLOR);
   assign accept_hum = (state == ST_TURN) && hum_turn && hum_valid;
   assign accept_ai  = (state == ST_TURN) && !hum_turn && ai_started && ai_dir_valid;
   assign accept     = accept_hum || accept_ai;
   assign ai_fire    = (state == ST_TURN) && !hum_turn && !ai_started && ai_idle;
   assign dir_in     = hum_turn ? hum_dir : ai_dir;
   assign illegal    = |(mem_rdata & dir_bit);
   assign stuck      = ((dst_mask | opp_bit) == 8'hFF);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (game_start) state_nxt = ST_START;
         ST_START:  state_nxt = ST_TURN;
         ST_TURN:   if (accept) state_nxt = ST_RD_SRC;
         ST_RD_SRC: state_nxt = ST_CHK;
         ST_CHK: begin
            if (illegal) state_nxt = hum_turn ? ST_TURN : ST_DONE;
            else         state_nxt = ST_RD_DST;
         end
         ST_RD_DST: state_nxt = ST_WR_SRC;
         ST_WR_SRC: state_nxt = ST_WR_DST;
         ST_WR_DST: state_nxt = ST_UPDATE;
         ST_UPDATE: begin
            if (dst_y == Y_GOAL || dst_y == 8'd0 || stuck) state_nxt = ST_DONE;
            else                                            state_nxt = ST_TURN;
         end
         ST_DONE:   if (game_start) state_nxt = ST_START;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      hum_ready    = (state == ST_TURN) && hum_turn;
      ai_turn      = ai_fire;
      mem_rd       = (state == ST_RD_SRC) || (state == ST_RD_DST);
      mem_we       = (state == ST_WR_SRC) || (state == ST_WR_DST);
      mem_addr     = 16'd0;
      mem_wdata    = 8'd0;
      move_done    = (state == ST_UPDATE);
      move_reject  = (state == ST_CHK) && illegal && hum_turn;
      winner_valid = (state == ST_DONE);
      winner       = winner_q;
      case (state)
         ST_RD_SRC: mem_addr = src_addr;
         ST_RD_DST: mem_addr = dst_addr;
         ST_WR_SRC: begin
            mem_addr  = src_addr;
            mem_wdata = src_mask | dir_bit;
         end
         ST_WR_DST: begin
            mem_addr  = dst_addr;
            mem_wdata = dst_mask | opp_bit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ball_x_q   <= X_MID;
         ball_y_q   <= Y_MID;
         turn_q     <= COLOR_BLUE;
         dir_q      <= 3'd0;
         src_mask   <= 8'd0;
         dst_mask   <= 8'd0;
         ai_started <= 1'b0;
         winner_q   <= 1'b0;
      end else begin
         case (state)
            ST_START: begin
               ball_x_q   <= X_MID;
               ball_y_q   <= Y_MID;
               turn_q     <= COLOR_BLUE;
               winner_q   <= 1'b0;
               ai_started <= 1'b0;
            end
            ST_TURN: begin
               if (ai_fire) ai_started <= 1'b1;
               if (accept) begin
                  dir_q      <= dir_in;
                  ai_started <= 1'b0;
               end
            end
            ST_CHK: begin
               src_mask <= mem_rdata;
               if (illegal && !hum_turn) winner_q <= ~AI_COLOR;
            end
            ST_WR_SRC: dst_mask <= mem_rdata;
            ST_UPDATE: begin
               ball_x_q <= dst_x;
               ball_y_q <= dst_y;
               // A previously visited destination is a bounce: the mover keeps the turn.
               if (dst_y == Y_GOAL)       winner_q <= COLOR_BLUE;
               else if (dst_y == 8'd0)    winner_q <= COLOR_RED;
               else if (stuck)            winner_q <= ~turn_q;
               else if (dst_mask == 8'd0) turn_q   <= ~turn_q;
            end
            default: ;
         endcase
      end
   end

   assign ball_x = ball_x_q;
   assign ball_y = ball_y_q;
   assign turn   = turn_q;

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter with a board RAM model and hand-computed expectations.
module tb_move_arbiter;
   import paper_soccer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, game_start, hum_valid, hum_ready, ai_turn, ai_dir_valid, ai_idle;
   logic [2:0]  hum_dir, ai_dir;
   logic [7:0]  ball_x, ball_y, mem_wdata, mem_rdata;
   logic        turn, mem_rd, mem_we, move_done, move_reject, winner_valid, winner;
   logic [15:0] mem_addr;

   move_arbiter #(.WIDTH(8), .LENGTH(10), .AI_COLOR(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .game_start(game_start),
      .hum_valid(hum_valid), .hum_dir(hum_dir), .hum_ready(hum_ready),
      .ai_turn(ai_turn), .ai_dir_valid(ai_dir_valid), .ai_dir(ai_dir), .ai_idle(ai_idle),
      .ball_x(ball_x), .ball_y(ball_y), .turn(turn),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .move_done(move_done), .move_reject(move_reject),
      .winner_valid(winner_valid), .winner(winner)
   );

   // Board RAM model with one-cycle read latency, a bench load port and a write log.
   logic [7:0]  mem [0:127];
   logic        clr, ld0_en, ld1_en;
   logic [15:0] ld0_addr, ld1_addr;
   logic [7:0]  ld0_data, ld1_data;
   int          wr_cnt = 0;
   logic [15:0] wr_addr [0:3];
   logic [7:0]  wr_data [0:3];
   int          ai_pulses = 0;

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr[6:0]];
      if (mem_we) begin
         mem[mem_addr[6:0]] <= mem_wdata;
         if (wr_cnt < 4) begin
            wr_addr[wr_cnt] <= mem_addr;
            wr_data[wr_cnt] <= mem_wdata;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (clr) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
         wr_cnt <= 0;
      end
      if (ld0_en) mem[ld0_addr[6:0]] <= ld0_data;
      if (ld1_en) mem[ld1_addr[6:0]] <= ld1_data;
      if (ai_turn) ai_pulses <= ai_pulses + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic new_game(input logic [15:0] a0, input logic [7:0] d0,
                           input logic [15:0] a1, input logic [7:0] d1);
      @(negedge clk);
      rst_n = 1'b0; hum_valid = 1'b0; ai_dir_valid = 1'b0; game_start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; clr = 1'b1; game_start = 1'b1;
      ld0_en = 1'b1; ld0_addr = a0; ld0_data = d0;
      ld1_en = 1'b1; ld1_addr = a1; ld1_data = d1;
      @(negedge clk);
      clr = 1'b0; ld0_en = 1'b0; ld1_en = 1'b0; game_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_end(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 12; n++) begin
         if (move_done || winner_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check(name, ok, 1);
   endtask

   task automatic hum_move(input logic [2:0] d);
      bit ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (hum_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("hum_ready_seen", ok, 1);
      hum_dir = d; hum_valid = 1'b1;
      @(negedge clk);
      hum_valid = 1'b0;
      wait_end("hum_move_end");
   endtask

   task automatic ai_move(input logic [2:0] d);
      bit ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (ai_turn) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("ai_turn_seen", ok, 1);
      @(negedge clk);
      ai_dir = d; ai_dir_valid = 1'b1;
      @(negedge clk);
      ai_dir_valid = 1'b0;
      wait_end("ai_move_end");
   endtask

   typedef struct {
      logic [2:0]  dir;
      logic [7:0]  src;
      logic [15:0] daddr;
      logic [7:0]  dst;
      bit          rej;
      logic [7:0]  sw, dw, x, y;
      bit          t, wv, w;
      int          ai;
   } vec_t;

   vec_t vecs [9];
   int   rej_cyc, done_cyc, ai_cnt, p0, bad;
   logic rdy3;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Ball starts at (4,5), source address 49; all moves by blue (human).
      vecs[0] = '{DIR_A, 8'h00, 16'd58, 8'h00, 1'b0, 8'h01, 8'h10, 8'd4, 8'd6, 1'b1, 1'b0, 1'b0, 1};
      vecs[1] = '{DIR_C, 8'h00, 16'd50, 8'h04, 1'b0, 8'h04, 8'h44, 8'd5, 8'd5, 1'b0, 1'b0, 1'b0, 0};
      vecs[2] = '{DIR_A, 8'h01, 16'd58, 8'h00, 1'b1, 8'h00, 8'h00, 8'd4, 8'd5, 1'b0, 1'b0, 1'b0, 0};
      vecs[3] = '{DIR_E, 8'h00, 16'd40, 8'h00, 1'b0, 8'h10, 8'h01, 8'd4, 8'd4, 1'b1, 1'b0, 1'b0, 1};
      vecs[4] = '{DIR_B, 8'h80, 16'd59, 8'h00, 1'b0, 8'h82, 8'h20, 8'd5, 8'd6, 1'b1, 1'b0, 1'b0, 1};
      vecs[5] = '{DIR_H, 8'h00, 16'd57, 8'hF7, 1'b0, 8'h80, 8'hFF, 8'd3, 8'd6, 1'b0, 1'b1, 1'b1, 0};
      vecs[6] = '{DIR_G, 8'h40, 16'd48, 8'h00, 1'b1, 8'h00, 8'h00, 8'd4, 8'd5, 1'b0, 1'b0, 1'b0, 0};
      vecs[7] = '{DIR_F, 8'h00, 16'd39, 8'h10, 1'b0, 8'h20, 8'h12, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0, 0};
      vecs[8] = '{DIR_D, 8'h00, 16'd41, 8'h00, 1'b0, 8'h08, 8'h80, 8'd5, 8'd4, 1'b1, 1'b0, 1'b0, 1};

      rst_n = 1'b0; game_start = 1'b0; hum_valid = 1'b0; hum_dir = 3'd0;
      ai_dir_valid = 1'b0; ai_dir = 3'd0; ai_idle = 1'b1;
      clr = 1'b1; ld0_en = 1'b0; ld1_en = 1'b0;
      ld0_addr = 16'd0; ld1_addr = 16'd0; ld0_data = 8'd0; ld1_data = 8'd0;
      repeat (3) @(negedge clk);
      clr = 1'b0;

      check("rst_ball_x", ball_x, 4);
      check("rst_ball_y", ball_y, 5);
      check("rst_turn", turn, 0);
      check("rst_strobes", {hum_ready, ai_turn, mem_rd, mem_we, move_done, move_reject}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_winner", {winner_valid, winner}, 0);

      for (int v = 0; v < 9; v++) begin
         new_game(16'd49, vecs[v].src, vecs[v].daddr, vecs[v].dst);
         check("v_hum_ready", hum_ready, 1);
         hum_dir = vecs[v].dir; hum_valid = 1'b1;
         @(negedge clk);
         hum_valid = 1'b0;
         rej_cyc = 0; done_cyc = 0; ai_cnt = 0; rdy3 = 1'b0;
         for (int k = 1; k <= 10; k++) begin
            if (move_reject && rej_cyc == 0) rej_cyc = k;
            if (move_done && done_cyc == 0) done_cyc = k;
            if (ai_turn) ai_cnt++;
            if (k == 3) rdy3 = hum_ready;
            if (k < 10) @(negedge clk);
         end
         if (vecs[v].rej) begin
            check("v_reject_cycle", rej_cyc, 2);
            check("v_reject_no_done", done_cyc, 0);
            check("v_reject_no_write", wr_cnt, 0);
            check("v_reject_ready_again", rdy3, 1);
         end else begin
            check("v_done_cycle", done_cyc, 6);
            check("v_no_reject", rej_cyc, 0);
            check("v_write_count", wr_cnt, 2);
            check("v_src_addr", wr_addr[0], 49);
            check("v_src_data", wr_data[0], vecs[v].sw);
            check("v_dst_addr", wr_addr[1], vecs[v].daddr);
            check("v_dst_data", wr_data[1], vecs[v].dw);
         end
         check("v_ball_x", ball_x, vecs[v].x);
         check("v_ball_y", ball_y, vecs[v].y);
         check("v_turn", turn, vecs[v].t);
         check("v_winner_valid", winner_valid, vecs[v].wv);
         check("v_winner", winner, vecs[v].w);
         check("v_ai_turn_count", ai_cnt, vecs[v].ai);
      end

      // Red AI scores from (4,1); (4,2) is preset visited so blue bounces there.
      new_game(16'd22, 8'h04, 16'd22, 8'h04);
      p0 = ai_pulses;
      hum_move(DIR_E);
      ai_move(DIR_E);
      hum_move(DIR_E);
      @(negedge clk);
      check("b_bounce_turn", turn, 0);
      check("b_bounce_hum_ready", hum_ready, 1);
      check("b_bounce_ball_y", ball_y, 2);
      hum_move(DIR_E);
      ai_move(DIR_E);
      @(negedge clk);
      check("b_goal_ball_x", ball_x, 4);
      check("b_goal_ball_y", ball_y, 0);
      check("b_goal_winner_valid", winner_valid, 1);
      check("b_goal_winner", winner, 1);
      check("b_ai_pulses", ai_pulses - p0, 2);

      // Reset asserted while the destination write is on the bus.
      new_game(16'd49, 8'h00, 16'd58, 8'h00);
      hum_dir = DIR_A; hum_valid = 1'b1;
      @(negedge clk);
      hum_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("c_wrdst_we", mem_we, 1);
      check("c_wrdst_addr", mem_addr, 58);
      rst_n = 1'b0;
      @(negedge clk);
      check("c_rst_we", mem_we, 0);
      check("c_rst_ball", {ball_x, ball_y}, {8'd4, 8'd5});
      check("c_rst_done", move_done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("c_idle_strobes", {hum_ready, move_done, mem_rd, mem_we}, 0);
      game_start = 1'b1;
      @(negedge clk);
      game_start = 1'b0;
      @(negedge clk);
      check("c_restart_ready", hum_ready, 1);

      // Human strobes during the AI turn are ignored; then the AI plays an illegal move.
      new_game(16'd49, 8'h00, 16'd58, 8'h00);
      hum_move(DIR_A);
      p0 = ai_pulses;
      hum_dir = DIR_C; hum_valid = 1'b1;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (hum_ready || mem_rd || mem_we || move_reject || move_done) bad++;
      end
      hum_valid = 1'b0;
      check("d_hum_ignored", bad, 0);
      check("d_ball_y", ball_y, 6);
      check("d_ai_pulse_once", ai_pulses - p0, 1);
      ai_dir = DIR_E; ai_dir_valid = 1'b1;
      @(negedge clk);
      ai_dir_valid = 1'b0;
      wait_end("d_ai_illegal_end");
      check("d_ai_illegal_winner_valid", winner_valid, 1);
      check("d_ai_illegal_winner", winner, 0);
      check("d_ai_illegal_ball", {ball_x, ball_y}, {8'd4, 8'd6});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/move_arbiter.md
# move_arbiter

Turn controller for paper-soccer play. It owns the ball position and the board edge memory, and alternates turns between the human keypad path and the AI search FSM. Each requested direction is checked against the edge memory, both endpoint masks are updated, bounces grant an extra move, and goals and stuck positions end the game. It sits between the input decoder, the AI `FSM` and the shared board RAM.

## Interface
- `WIDTH`, default 8: board columns; x ranges 0..WIDTH.
- `LENGTH`, default 10: board rows; y ranges 0..LENGTH, goal rows are 0 and LENGTH.
- `AI_COLOR`, default 1: colour played by the AI (0 = blue, 1 = red).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `game_start` in 1: pulse; recentres the ball and starts a game.
- `hum_valid` in 1, `hum_dir` in 3, `hum_ready` out 1: human move handshake.
- `ai_turn` out 1: one-cycle pulse that starts the AI (drives `my_turn`).
- `ai_dir_valid` in 1, `ai_dir` in 3: AI result strobe and direction.
- `ai_idle` in 1: AI is idle.
- `ball_x`, `ball_y` out 8 each: current ball point.
- `turn` out 1: colour to move.
- `mem_addr` out 16: board RAM address.
- `mem_rd` out 1: board RAM read strobe.
- `mem_we` out 1: board RAM write enable.
- `mem_wdata` out 8: board RAM write data.
- `mem_rdata` in 8: board RAM read data.
- `move_done` out 1: pulse per applied move.
- `move_reject` out 1: pulse per rejected move.
- `winner_valid` out 1: level, held until the next `game_start`.
- `winner` out 1: colour of the winner.

## Operation
- Directions: a0 (0,+1), b1 (+1,+1), c2 (+1,0), d3 (+1,−1), e4 (0,−1), f5 (−1,−1), g6 (−1,0), h7 (−1,+1). Opposite direction = (dir+4) mod 8. Edge-mask bit n = direction n used.
- RAM word per point holds its 8-bit edge mask. Address = y*(WIDTH+1)+x. The board initialiser presets out-of-field edges; goal-mouth edges are left clear.
- Blue attacks y=LENGTH; red attacks y=0.
- States:
  - IDLE → START on `game_start`.
  - START: ball=(WIDTH/2, LENGTH/2), turn=0. Go to TURN.
  - TURN: if turn==AI_COLOR and `ai_idle`, pulse `ai_turn` once and wait for `ai_dir_valid`. Otherwise `hum_ready`=1 and accept on `hum_valid`. Latch dir, go to RD_SRC.
  - RD_SRC → CHK.
  - CHK: if src bit[dir] is set, the move is illegal.
    - Human illegal move: pulse `move_reject`, back to TURN.
    - AI illegal move: winner=~AI_COLOR, go to DONE.
    - Otherwise go to RD_DST.
  - RD_DST → WR_SRC: write src|(1<<dir).
  - WR_SRC → WR_DST: write dst|(1<<opp).
  - WR_DST → UPDATE.
  - UPDATE: ball=dst, pulse `move_done`.
    - dst y==LENGTH: blue wins, go to DONE.
    - dst y==0: red wins, go to DONE.
    - New dst mask == 8'hFF (stuck): mover loses, go to DONE.
    - Old dst mask != 0 (bounce): same player moves again.
    - Otherwise toggle turn.
    - Non-DONE cases return to TURN.
  - DONE: `winner_valid`=1; a `game_start` pulse goes to START.
- `hum_valid` is ignored outside human TURN. `ai_dir_valid` is ignored outside AI TURN.
- `game_start` outside IDLE/DONE is ignored.

## Timing
- `mem_rdata` is valid the cycle after `mem_rd`.
- Legal move latency, accept to `move_done`: 6 cycles (RD_SRC, CHK, RD_DST, WR_SRC, WR_DST, UPDATE).
- Reject latency: `move_reject` is asserted 2 cycles after accept.
- `ai_turn` fires once per AI turn, including repeat turns after a bounce.
- Reset values:
  - state IDLE
  - ball (WIDTH/2, LENGTH/2)
  - turn 0
  - all strobes 0
  - `mem_addr` 0, `mem_wdata` 0
  - `winner_valid` 0, `winner` 0
- `rst_n` low in any state, including mid-write: `mem_we`=0 from the next edge, with no partial-move completion.
- Coordinates are 8-bit unsigned. dx/dy are applied as sign-extended −1/0/+1. Because of the preset edges, no under- or overflow is reachable.

## Structure
- Shared package `paper_soccer_pkg` holds:
  - direction constants a..h
  - colour constants red/blue
  - state encoding
  - `opp_dir` function
- Sub-module `move_decoder`, combinational: dir → dx, dy, `dir_bit`, `opp_bit`. It is reused by the AI path.
- Address computation is a constant-multiply inside the controller.

## Test plan
- WIDTH=8, LENGTH=10, empty masks: human `hum_dir`=a from (4,5) → write addr 49 data 8'h01, write addr 58 data 8'h10, ball (4,6), turn=1, `ai_turn` pulse.
- Destination mask 8'h04 (visited): human plays c → bounce, turn stays 0, no `ai_turn`.
- Source mask bit0 set: human plays a → `move_reject` 2 cycles after accept, no `mem_we`, `hum_ready` high again.
- Red AI at (4,1): `ai_dir`=e → ball (4,0), `winner_valid`=1, `winner`=1.
- `rst_n`=0 during WR_DST → `mem_we`=0 next cycle, ball (4,5), state IDLE.
- `hum_valid` asserted during an AI turn → `hum_ready`=0, no memory access, move ignored.
